mmio_timer: RTL
===============

Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral that acts as the responder on the core's data-memory-side interface: cs, rd_en, wr_en, addr, write_data, mask, read_data.
- Sits beside data memory in the memory/writeback stage; external address decode drives cs.
- Provides a prescaled 32-bit up-counter, compare match, auto-reload and a level interrupt.
- Read data is combinational so the core can write it back in the same cycle, exactly as it does for data memory.

Parameters:
- DATA_W, 32, width of the bus and of the COUNT/COMPARE registers.
- PRESC_W, 8, width of the prescaler field and of the prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  active-high peripheral select from the address decoder.
- rd_en  input  1  read strobe; qualified by cs.
- wr_en  input  1  write strobe; qualified by cs.
- addr  input  32  byte address; only addr[3:2] is decoded, all other bits are ignored.
- write_data  input  DATA_W  write data.
- mask  input  4  byte enables; mask[i] enables write_data[8i+7:8i].
- read_data  output  DATA_W  combinational read data.
- irq  output  1  level interrupt: STATUS.match AND CTRL.irq_en.

Behaviour:
- Register map (addr[3:2]):
  - 0 = CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bits[8+PRESC_W-1:8] presc. All other bits read 0 and ignore writes.
  - 1 = COUNT (R/W).
  - 2 = COMPARE (R/W).
  - 3 = STATUS: bit0 match, write-1-to-clear; other bits read 0.
- Reset (asynchronous, takes effect immediately, including mid-count):
  - CTRL=0, COUNT=0, COMPARE=all-ones, STATUS=0, prescaler counter=0.
  - irq=0.
  - read_data=0, since no access can be active during reset.
- Read: read_data = selected register when cs&rd_en, else 0. Combinational, zero latency, no side effects; reading STATUS does not clear it.
- Write: when cs&wr_en, the byte lanes with mask[i]=1 update on the clock edge. Lanes with mask[i]=0 keep their value.
  - mask=0000 is a no-op.
  - STATUS write clears match only if lane 0 is enabled and write_data[0]=1.
- rd_en and wr_en together: read returns the pre-write value; the write lands on the edge.
- Prescaler:
  - pre counts only while enable=1.
  - tick = enable && (pre == presc); on tick pre<=0, else pre<=pre+1.
  - presc=0 gives a tick every cycle; presc=N gives a tick every N+1 cycles.
  - pre<=0 when enable=0 and on any CTRL write that enables lane 1 (presc byte).
- Counter, on tick:
  - If COUNT==COMPARE: STATUS.match<=1. COUNT<=0 if auto_reload, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Increment wraps 2^DATA_W-1 -> 0 with no flag.
  - Auto-reload period is COMPARE+1 ticks.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the written bytes win, unwritten bytes take the tick result.
  - STATUS clear in the same cycle as a new match: set wins, match stays 1.
  - A COMPARE write in the tick cycle takes effect from the next tick; the current cycle uses the old COMPARE.
- Disable (enable 1->0): COUNT and STATUS hold, pre clears, irq holds its level.
- irq is combinational from registered state, so it is glitch-free relative to clk.

Test Plan:
- Reset check: assert reset mid-count (COUNT=0x1234, match=1) -> all registers return to their reset values immediately, irq=0; a read of COMPARE returns 0xFFFFFFFF.
- Auto-reload period:
  - Setup: write COMPARE=4 and CTRL=0x0000_0107 (enable, auto_reload, irq_en, presc=1).
  - Required: a tick every 2 cycles; COUNT sequence 0,1,2,3,4,0.
  - Required: match and irq rise in the cycle after the tick with COUNT==4, i.e. 10 cycles after the enable edge.
- One-shot / wrap:
  - Setup: auto_reload=0, presc=0, COMPARE=0xFFFFFFFE, COUNT written to 0xFFFFFFFD.
  - Required: match sets once; COUNT goes through 0xFFFFFFFF -> 0 -> 1 with no second flag.
- Byte-masked write: COUNT=0x11223344, then write 0xAABBCCDD with mask=0101 -> COUNT reads 0x11BB33DD; mask=0000 -> COUNT is unchanged.
- Collisions:
  - STATUS W1C in the same cycle as a match -> match stays 1.
  - COUNT write of 0x100 (mask=1111) in a tick cycle -> COUNT=0x100, not old+1.
  - rd_en&wr_en to COMPARE -> read_data shows the old value.
- Deselect: rd_en=1 with cs=0 -> read_data=0; wr_en=1 with cs=0 -> no register changes.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload and level irq.
// Ports: clk, reset, cs/rd_en/wr_en/addr/write_data/mask bus in, read_data/irq out.
module mmio_timer #(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        mask,
  output logic [DATA_W-1:0] read_data,
  output logic              irq
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CNT  = 2'd1;
  localparam logic [1:0] A_CMP  = 2'd2;
  localparam logic [1:0] A_STS  = 2'd3;

  logic               r_en;
  logic               r_ar;
  logic               r_ie;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pre;
  logic [DATA_W-1:0]  r_count;
  logic [DATA_W-1:0]  r_compare;
  logic               r_match;

  logic [DATA_W-1:0]  w_bmask;
  logic [DATA_W-1:0]  w_ctrl;
  logic [DATA_W-1:0]  w_ctrl_new;
  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_cnt;
  logic               w_wr_cmp;
  logic               w_wr_sts;
  logic               w_tick;
  logic               w_hit;
  logic               w_clr;
  logic [DATA_W-1:0]  w_cnt_tick;
  logic [DATA_W-1:0]  w_cnt_next;
  logic [PRESC_W-1:0] w_pre_next;
  logic               w_unused;

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_bm
    assign w_bmask[8*i +: 8] = {8{mask[i]}};
  end

  assign w_ctrl = {{(DATA_W-8-PRESC_W){1'b0}}, r_presc,
                   5'b0, r_ie, r_ar, r_en};
  assign w_ctrl_new = (w_ctrl & ~w_bmask) | (write_data & w_bmask);

  assign w_wr      = cs & wr_en;
  assign w_wr_ctrl = w_wr && (addr[3:2] == A_CTRL);
  assign w_wr_cnt  = w_wr && (addr[3:2] == A_CNT);
  assign w_wr_cmp  = w_wr && (addr[3:2] == A_CMP);
  assign w_wr_sts  = w_wr && (addr[3:2] == A_STS);

  assign w_tick = r_en && (r_pre == r_presc);
  assign w_hit  = w_tick && (r_count == r_compare);
  assign w_clr  = w_wr_sts && mask[0] && write_data[0];

  assign w_cnt_tick = !w_tick ? r_count :
                      (w_hit && r_ar) ? '0 :
                      r_count + {{(DATA_W-1){1'b0}}, 1'b1};

  // Written bytes override the tick result; other bytes keep it.
  assign w_cnt_next = w_wr_cnt ?
                      ((w_cnt_tick & ~w_bmask) | (write_data & w_bmask)) :
                      w_cnt_tick;

  // Changing the prescale value restarts the prescale phase.
  assign w_pre_next = (!r_en || w_tick || (w_wr_ctrl && mask[1])) ? '0 :
                      r_pre + {{(PRESC_W-1){1'b0}}, 1'b1};

  assign irq = r_match & r_ie;

  assign w_unused = ^{addr[31:4], addr[1:0], w_ctrl_new[7:3],
                      w_ctrl_new[DATA_W-1:8+PRESC_W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_ar      <= 1'b0;
      r_ie      <= 1'b0;
      r_presc   <= '0;
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '1;
      r_match   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= w_ctrl_new[0];
        r_ar    <= w_ctrl_new[1];
        r_ie    <= w_ctrl_new[2];
        r_presc <= w_ctrl_new[8 +: PRESC_W];
      end
      if (w_wr_cmp)
        r_compare <= (r_compare & ~w_bmask) | (write_data & w_bmask);
      r_pre   <= w_pre_next;
      r_count <= w_cnt_next;
      // A new match outranks a same-cycle clear.
      r_match <= w_hit | (r_match & ~w_clr);
    end
  end

  always_comb begin
    read_data = '0;
    if (cs && rd_en && !reset) begin
      case (addr[3:2])
        A_CTRL:  read_data = w_ctrl;
        A_CNT:   read_data = r_count;
        A_CMP:   read_data = r_compare;
        A_STS:   read_data = {{(DATA_W-1){1'b0}}, r_match};
        default: read_data = '0;
      endcase
    end
  end

endmodule
